// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: bus bundle between the fetch unit, instruction memory and the IF/ID stage
// Signals: imem_req_valid/ready/addr (request), imem_rsp_valid/data (in-order response),
//          redirect_valid/pc (flow change pulse), if_id_stall (back-pressure),
//          if_valid/pc/pc_p4/instr (IF-side inputs of the IF/ID register).
// Modports: master = fetch unit, slave = memory and pipeline side.
interface instr_fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_stall;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_p4;
   logic [31:0] if_instr;
   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_pc, if_pc_p4, if_instr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_id_stall
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_pc_p4, if_instr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_id_stall
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch front-end owning the PC, issuing in-order imem requests and queueing responses
// Ports: clk; rstn (synchronous, active-low); bus (instr_fetch_unit_if.master) carrying the imem
//        request/response handshake, redirect pulse, IF/ID stall and the if_* outputs.
// Optional feature: define IFU_RSP_BYPASS_EN to forward a response straight to if_* when the queue
//        is empty (zero-cycle response->IF latency); otherwise responses always pass through the queue.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          FQ_DEPTH  = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic                clk,
   input logic                rstn,
   instr_fetch_unit_if.master bus
);
   localparam int CW = $clog2(FQ_DEPTH + 1);
   localparam int AW = $clog2(FQ_DEPTH);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);
   logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d, cnt_q, cnt_d, drop_q, drop_d;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [31:0]   pc_mem_q [FQ_DEPTH];
   logic [31:0]   pc_mem_d [FQ_DEPTH];
   logic [31:0]   ins_mem_q [FQ_DEPTH];
   logic [31:0]   ins_mem_d [FQ_DEPTH];
   logic [CW:0]   credit;
   logic [31:0]   redir_pc, pc_o;
   logic          req_valid, accept, rsp, keep, byp, head_v, if_v, pop, qpop, push;
   // Requests plus queued entries never exceed the queue size, so every response has a slot.
   assign credit    = {1'b0, inflight_q} + {1'b0, cnt_q};
   assign redir_pc  = bus.redirect_pc & 32'hFFFF_FFFC;
   assign req_valid = rstn && !bus.redirect_valid && credit < DEPTH_W;
   assign accept    = req_valid && bus.imem_req_ready;
   assign rsp       = rstn && bus.imem_rsp_valid;
   // A response is kept only if it is not owed to an earlier redirect and no redirect is happening now.
   assign keep      = rsp && drop_q == '0 && !bus.redirect_valid;
`ifdef IFU_RSP_BYPASS_EN
   assign byp       = keep && cnt_q == '0;
`else
   assign byp       = 1'b0;
`endif
   assign head_v    = rstn && cnt_q != '0;
   assign if_v      = head_v || byp;
   assign pop       = if_v && !bus.if_id_stall && !bus.redirect_valid;
   assign qpop      = pop && head_v;
   // A bypassed response that IF/ID takes this cycle never enters the queue.
   assign push      = keep && !(byp && pop);
   assign pc_o      = byp ? rsp_pc_q : head_v ? pc_mem_q[rd_q] : 32'h0;
   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.if_valid       = if_v;
   assign bus.if_pc          = pc_o;
   assign bus.if_pc_p4       = if_v ? pc_o + 32'd4 : 32'h0;
   assign bus.if_instr       = byp ? bus.imem_rsp_data : head_v ? ins_mem_q[rd_q] : NOP_INSTR;
   always_comb begin
      pc_mem_d   = pc_mem_q;
      ins_mem_d  = ins_mem_q;
      inflight_d = inflight_q + CW'(accept) - CW'(rsp);
      cnt_d      = cnt_q + CW'(push) - CW'(qpop);
      wr_d       = wr_q + AW'(push);
      rd_d       = rd_q + AW'(qpop);
      drop_d     = drop_q - CW'(rsp && drop_q != '0);
      fetch_pc_d = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
      rsp_pc_d   = keep ? rsp_pc_q + 32'd4 : rsp_pc_q;
      if (push) begin
         pc_mem_d[wr_q]  = rsp_pc_q;
         ins_mem_d[wr_q] = bus.imem_rsp_data;
      end
      // Everything still outstanding after this cycle's response belongs to the old flow.
      if (bus.redirect_valid) begin
         fetch_pc_d = redir_pc;
         rsp_pc_d   = redir_pc;
         cnt_d      = '0;
         rd_d       = '0;
         wr_d       = '0;
         drop_d     = inflight_d;
      end
      if (!rstn) begin
         fetch_pc_d = RESET_PC;
         rsp_pc_d   = RESET_PC;
         inflight_d = '0;
         cnt_d      = '0;
         drop_d     = '0;
         rd_d       = '0;
         wr_d       = '0;
      end
   end
   always_ff @(posedge clk) begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      pc_mem_q   <= pc_mem_d;
      ins_mem_q  <= ins_mem_d;
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: self-checking bench for instr_fetch_unit with a latency-programmable imem,
// a queue-based reference model checked every cycle, and directed scenarios with literal expectations.
// Honours IFU_RSP_BYPASS_EN when defined, matching the design build.
module tb_instr_fetch_unit;
   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFU_RSP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct { logic [31:0] addr; int due; bit live; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   logic clk, rstn;
   instr_fetch_unit_if b ();
   instr_fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rstn(rstn), .bus(b)
   );
   int checks = 0, errors = 0, cyc = 0, lat = 1;
   logic st = 1'b0, rdy = 1'b1;
   req_t mq[$];
   ent_t m_q[$];
   logic [31:0] m_fetch_pc = 32'h0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // Reference: a program-ordered queue of delivered instructions, stale-tagging of outstanding
   // requests on redirect, and the credit rule over outstanding requests plus queued entries.
   always @(negedge clk) begin : scoreboard
      req_t e;
      logic hv, hl, byp, ev, erv, pop, acc;
      logic [31:0] ha, epc, ein;
      hv = b.imem_rsp_valid && mq.size() > 0;
      hl = 1'b0;
      ha = 32'h0;
      if (mq.size() > 0) begin
         hl = mq[0].live;
         ha = mq[0].addr;
      end
      byp = BYP && rstn && hv && hl && !b.redirect_valid && m_q.size() == 0;
      ev  = rstn && (m_q.size() > 0 || byp);
      epc = 32'h0;
      ein = NOP;
      if (rstn && m_q.size() > 0) begin
         epc = m_q[0].pc;
         ein = m_q[0].instr;
      end else if (byp) begin
         epc = ha;
         ein = mem_word(ha);
      end
      erv = rstn && !b.redirect_valid && (mq.size() + m_q.size() < DEPTH);
      chk("if_valid", 32'(b.if_valid), 32'(ev));
      chk("if_pc", b.if_pc, epc);
      chk("if_pc_p4", b.if_pc_p4, ev ? epc + 32'd4 : 32'h0);
      chk("if_instr", b.if_instr, ein);
      chk("imem_req_valid", 32'(b.imem_req_valid), 32'(erv));
      if (erv) chk("imem_req_addr", b.imem_req_addr, m_fetch_pc);
      acc = b.imem_req_valid && b.imem_req_ready;
      pop = ev && !b.if_id_stall && !b.redirect_valid;
      if (!rstn) begin
         m_q.delete();
         mq.delete();
         m_fetch_pc = 32'h0;
      end else begin
         if (pop && m_q.size() > 0) m_q.delete(0);
         if (hv) begin
            e = mq[0];
            mq.delete(0);
            if (e.live && !b.redirect_valid && !(byp && pop)) m_q.push_back('{e.addr, mem_word(e.addr)});
         end
         if (b.redirect_valid) begin
            m_q.delete();
            foreach (mq[i]) mq[i].live = 1'b0;
            m_fetch_pc = {b.redirect_pc[31:2], 2'b00};
         end else if (acc) begin
            mq.push_back('{b.imem_req_addr, cyc + lat, 1'b1});
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
   end
   // One clock of stimulus; the memory answers the oldest request once its latency has elapsed.
   task automatic step(input logic rn, input logic rd, input logic [31:0] rpc, input logic ros);
      @(posedge clk);
      #1;
      cyc++;
      rstn = rn;
      b.if_id_stall = st;
      b.imem_req_ready = rdy;
      b.imem_rsp_valid = 1'b0;
      b.imem_rsp_data = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         b.imem_rsp_valid = 1'b1;
         b.imem_rsp_data = mem_word(mq[0].addr);
      end
      b.redirect_valid = rd || (ros && b.imem_rsp_valid);
      b.redirect_pc = rpc;
      #2;
   endtask
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
   initial begin : stim
      logic found;
      int nacc;
      logic [31:0] accs [3];
      logic [31:0] p4_seen;
      rstn = 1'b0;
      b.imem_req_ready = 1'b1;
      b.imem_rsp_valid = 1'b0;
      b.imem_rsp_data = 32'h0;
      b.redirect_valid = 1'b0;
      b.redirect_pc = 32'h0;
      b.if_id_stall = 1'b0;
      repeat (3) step(0, 0, 0, 0);
      chk("rst_req_valid", 32'(b.imem_req_valid), 0);
      chk("rst_if_valid", 32'(b.if_valid), 0);
      chk("rst_if_pc", b.if_pc, 0);
      chk("rst_if_pc_p4", b.if_pc_p4, 0);
      chk("rst_if_instr", b.if_instr, 32'h0000_0013);
      step(1, 0, 0, 0);
      chk("t1_first_req", 32'(b.imem_req_valid), 1);
      chk("t1_first_addr", b.imem_req_addr, 32'h0);
      for (int i = 0; i < (BYP ? 1 : 2); i++) step(1, 0, 0, 0);
      chk("t1_if_valid", 32'(b.if_valid), 1);
      chk("t1_if_pc", b.if_pc, 32'h0);
      chk("t1_if_pc_p4", b.if_pc_p4, 32'h4);
      chk("t1_if_instr", b.if_instr, 32'h1357_9BDF);
      repeat (6) step(1, 0, 0, 0);
      st = 1'b1;
      repeat (6) step(1, 0, 0, 0);
      chk("t2_req_held_off", 32'(b.imem_req_valid), 0);
      chk("t2_head_shown", 32'(b.if_valid), 1);
      st = 1'b0;
      repeat (6) step(1, 0, 0, 0);
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 16 && !found; i++) begin
         step(1, 0, 0, 0);
         found = mq.size() == 2;
      end
      chk("t3_two_inflight", 32'(found), 1);
      step(1, 1, 32'h100, 0);
      chk("t3_no_req_on_redirect", 32'(b.imem_req_valid), 0);
      found = 1'b0;
      for (int i = 0; i < 16 && !found; i++) begin
         step(1, 0, 0, 0);
         found = b.if_valid;
      end
      chk("t3_if_pc", b.if_pc, 32'h100);
      chk("t3_if_pc_p4", b.if_pc_p4, 32'h104);
      lat = 1;
      repeat (4) step(1, 0, 0, 0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step(1, 0, 32'h103, 1);
         found = b.redirect_valid;
      end
      chk("t4_redirect_on_rsp", 32'(found), 1);
      step(1, 0, 0, 0);
      chk("t4_req_valid", 32'(b.imem_req_valid), 1);
      chk("t4_req_addr", b.imem_req_addr, 32'h100);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (i > 0) step(1, 0, 0, 0);
         found = b.if_valid;
      end
      chk("t4_if_pc", b.if_pc, 32'h100);
      nacc = 0;
      accs = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      p4_seen = 32'hDEAD_BEEF;
      step(1, 1, 32'hFFFF_FFF8, 0);
      for (int i = 0; i < 30; i++) begin
         step(1, 0, 0, 0);
         if (b.imem_req_valid && b.imem_req_ready && nacc < 3) begin
            accs[nacc] = b.imem_req_addr;
            nacc++;
         end
         if (b.if_valid && b.if_pc == 32'hFFFF_FFFC) p4_seen = b.if_pc_p4;
      end
      chk("t5_addr0", accs[0], 32'hFFFF_FFF8);
      chk("t5_addr1", accs[1], 32'hFFFF_FFFC);
      chk("t5_addr2", accs[2], 32'h0000_0000);
      chk("t5_pc_p4_wrap", p4_seen, 32'h0);
      lat = 2;
      for (int i = 0; i < 24; i++) begin
         st = (i % 3) == 0;
         rdy = (i % 4) != 1;
         step(1, i == 13, 32'h40 + 32'(i), 0);
      end
      st = 1'b0;
      lat = 1;
      rdy = 1'b0;
      repeat (6) step(1, 0, 0, 0);
      rdy = 1'b1;
      step(1, 1, 32'h200, 0);
      step(1, 0, 0, 0);
      chk("t6_req_addr", b.imem_req_addr, 32'h200);
      step(1, 0, 0, 0);
      chk("t6_rsp_cycle_valid", 32'(b.if_valid), 32'(BYP));
      chk("t6_rsp_cycle_pc", b.if_pc, BYP ? 32'h200 : 32'h0);
      step(1, 0, 0, 0);
      chk("t6_next_valid", 32'(b.if_valid), 1);
      chk("t6_next_pc", b.if_pc, BYP ? 32'h204 : 32'h200);
      repeat (4) step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t6_rst_req_valid", 32'(b.imem_req_valid), 0);
      chk("t6_rst_if_valid", 32'(b.if_valid), 0);
      step(0, 0, 0, 0);
      chk("t6_rst_if_pc", b.if_pc, 0);
      chk("t6_rst_if_instr", b.if_instr, 32'h0000_0013);
      step(1, 0, 0, 0);
      chk("t6_restart_req", 32'(b.imem_req_valid), 1);
      chk("t6_restart_addr", b.imem_req_addr, 32'h0);
      repeat (10) step(1, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
